mips_div: RTL and testbench

//  Multi-cycle radix-2 restoring divider for DIV/DIVU, directly downstream of the

---
 rtl/mips_div_if.sv | 26 ++
 rtl/mips_div.sv | 142 ++++++++++++++
 tb/tb_mips_div.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_div_if.sv
// Divider request/response bundle between the E stage (master) and the
// multi-cycle divider (slave). Request fields are sampled together with start_i.
interface mips_div_if #(
   parameter int WIDTH = 32
);
   logic               start_i;
   logic               sign_i;
   logic               flush_i;
   logic [WIDTH-1:0]   opa_i;
   logic [WIDTH-1:0]   opb_i;
   logic               stall_o;
   logic               ready_o;
   logic [2*WIDTH-1:0] result_o;

   // E-stage side: issues requests, observes stall and result
   modport master (
      output start_i, sign_i, flush_i, opa_i, opb_i,
      input  stall_o, ready_o, result_o
   );

   // Divider side: consumes requests, produces stall and result
   modport slave (
      input  start_i, sign_i, flush_i, opa_i, opb_i,
      output stall_o, ready_o, result_o
   );
endinterface

// File: rtl/mips_div.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Operands are converted to magnitudes on acceptance, one quotient bit is
// produced per cycle, and the sign fix-up is applied on the way into DONE.
// Result layout is {HI = remainder, LO = quotient}.
module mips_div #(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst,
   mips_div_if.slave bus
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONES      = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DZERO = 2'd1,
      S_ON    = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Control state
   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               ready_q;
   logic [2*WIDTH-1:0] result_q;

   // Datapath state: quo_q starts as the dividend magnitude and fills with
   // quotient bits from the right as dividend bits shift out on the left.
   logic [WIDTH-1:0]   rem_q;
   logic [WIDTH-1:0]   quo_q;
   logic [WIDTH-1:0]   dvs_q;
   logic               sgn_q;
   logic               amsb_q;
   logic               bmsb_q;

   // Combinational step / fix-up values
   logic [WIDTH:0]     part_d;
   logic [WIDTH:0]     diff_d;
   logic               ge_d;
   logic [WIDTH-1:0]   rem_d;
   logic [WIDTH-1:0]   quo_d;
   logic [WIDTH-1:0]   rem_fix_d;
   logic [WIDTH-1:0]   quo_fix_d;
   logic               accept_d;
   logic               unused_diff_msb;

   // Two's-complement negation (wraps: most-negative maps to itself)
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return ~v + 1'b1;
   endfunction

   // Magnitude of an operand; unsigned operands pass through untouched
   function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v,
                                              input logic             sgn);
      return (sgn && v[WIDTH-1]) ? neg_w(v) : v;
   endfunction

   // A request is taken only from IDLE and never in the same cycle as a flush
   assign accept_d = (state_q == S_IDLE) && bus.start_i && !bus.flush_i;

   // One restoring step on the WIDTH+1-bit partial remainder, plus sign fix-up
   always_comb begin
      part_d    = {rem_q, quo_q[WIDTH-1]};
      ge_d      = (part_d >= {1'b0, dvs_q});
      diff_d    = part_d - {1'b0, dvs_q};
      rem_d     = ge_d ? diff_d[WIDTH-1:0] : part_d[WIDTH-1:0];
      quo_d     = {quo_q[WIDTH-2:0], ge_d};
      quo_fix_d = (sgn_q && (amsb_q ^ bmsb_q)) ? neg_w(quo_d) : quo_d;
      rem_fix_d = (sgn_q && amsb_q) ? neg_w(rem_d) : rem_d;
   end

   // A kept difference is always below the divisor, so its top bit is zero
   assign unused_diff_msb = diff_d[WIDTH];

   // Datapath registers: load magnitudes on accept, iterate while in ON
   always_ff @(posedge clk) begin
      if (accept_d) begin
         rem_q  <= '0;
         // For divide-by-zero the raw dividend is kept for the HI result
         quo_q  <= (bus.opb_i == '0) ? bus.opa_i : mag_w(bus.opa_i, bus.sign_i);
         dvs_q  <= mag_w(bus.opb_i, bus.sign_i);
         sgn_q  <= bus.sign_i;
         amsb_q <= bus.opa_i[WIDTH-1];
         bmsb_q <= bus.opb_i[WIDTH-1];
      end else if (state_q == S_ON) begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
      end
   end

   // Control FSM with registered ready/result; flush wins in every state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         ready_q  <= 1'b0;
         result_q <= '0;
      end else begin
         ready_q <= 1'b0;
         if (bus.flush_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (bus.start_i) begin
                     state_q <= (bus.opb_i == '0) ? S_DZERO : S_ON;
                     cnt_q   <= '0;
                  end
               end
               S_DZERO: begin
                  state_q  <= S_DONE;
                  ready_q  <= 1'b1;
                  result_q <= {quo_q, ONES};
               end
               S_ON: begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == LAST_STEP) begin
                     state_q  <= S_DONE;
                     ready_q  <= 1'b1;
                     result_q <= {rem_fix_d, quo_fix_d};
                  end
               end
               S_DONE: begin
                  // A start still asserted here belongs to the finished op
                  state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   // Stall is dropped in DONE so E advances in the cycle the result appears
   assign bus.stall_o  = accept_d || (state_q == S_ON) || (state_q == S_DZERO);
   assign bus.ready_o  = ready_q;
   assign bus.result_o = result_q;

endmodule

// File: tb/tb_mips_div.sv
// Bench for mips_div: directed corner cases, flush/reset mid-operation,
// back-to-back starts and random operands against an arithmetic model.
module tb_mips_div;

   logic clk;
   logic rst;
   int   errs;
   int   checks;
   logic [63:0] last_exp;

   mips_div_if #(.WIDTH(32)) dif ();

   mips_div #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: plain integer division, truncating toward zero
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
      longint sa, sb, q, r;
      logic [31:0] uq, ur;
      if (b == 32'h0) return {a, 32'hFFFFFFFF};
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return {r[31:0], q[31:0]};
      end
      uq = a / b;
      ur = a % b;
      return {ur, uq};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one single-cycle start and follow the op through to ready
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [63:0] exp, input string tag);
      int n;
      int lat;
      logic stall_ok;
      lat = (b == 32'h0) ? 1 : 32;
      @(negedge clk);
      dif.start_i = 1'b1;
      dif.sign_i  = sgn;
      dif.opa_i   = a;
      dif.opb_i   = b;
      #1;
      chk({tag, " stall_at_start"}, 64'(dif.stall_o), 64'd1);
      @(posedge clk); #1;
      dif.start_i = 1'b0;
      n = 0;
      stall_ok = 1'b1;
      while (!dif.ready_o && n < 100) begin
         if (!dif.stall_o) stall_ok = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      chk({tag, " latency"}, 64'(n), 64'(lat));
      chk({tag, " stall_held"}, 64'(stall_ok), 64'd1);
      chk({tag, " stall_in_done"}, 64'(dif.stall_o), 64'd0);
      chk({tag, " result"}, dif.result_o, exp);
      @(posedge clk); #1;
      chk({tag, " ready_width"}, 64'(dif.ready_o), 64'd0);
      chk({tag, " result_hold"}, dif.result_o, exp);
      last_exp = exp;
   endtask

   initial begin
      int n;
      int pulses;
      logic [31:0] a, b;
      logic        s;
      logic [63:0] e1, e2;

      errs = 0;
      checks = 0;
      rst = 1'b1;
      dif.start_i = 1'b0;
      dif.sign_i  = 1'b0;
      dif.flush_i = 1'b0;
      dif.opa_i   = '0;
      dif.opb_i   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset ready", 64'(dif.ready_o), 64'd0);
      chk("reset result", dif.result_o, 64'd0);
      chk("reset stall", 64'(dif.stall_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      last_exp = 64'd0;

      // Directed corner cases
      run_div(32'd7, 32'd2, 1'b0, {32'h1, 32'h3}, "divu_7_2");
      run_div(32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, "div_m7_2");
      run_div(32'd7, 32'hFFFFFFFE, 1'b1, {32'h1, 32'hFFFFFFFD}, "div_7_m2");
      run_div(32'h1234, 32'h0, 1'b0, {32'h1234, 32'hFFFFFFFF}, "dzero");
      run_div(32'hFFFFFFF0, 32'h0, 1'b1, {32'hFFFFFFF0, 32'hFFFFFFFF}, "dzero_signed");
      run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, "div_min_m1");
      run_div(32'h80000000, 32'hFFFFFFFF, 1'b0, {32'h80000000, 32'h0}, "divu_min_m1");
      run_div(32'hFFFFFFFF, 32'h1, 1'b0, {32'h0, 32'hFFFFFFFF}, "divu_max_1");

      // Flush at iteration 10: no ready, result untouched, stall released
      @(negedge clk);
      dif.start_i = 1'b1; dif.sign_i = 1'b0; dif.opa_i = 32'd1000; dif.opb_i = 32'd3;
      @(posedge clk); #1;
      dif.start_i = 1'b0;
      pulses = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (dif.ready_o) pulses++;
      end
      @(negedge clk);
      dif.flush_i = 1'b1;
      @(posedge clk); #1;
      dif.flush_i = 1'b0;
      chk("flush stall", 64'(dif.stall_o), 64'd0);
      chk("flush ready", 64'(dif.ready_o), 64'd0);
      repeat (40) begin
         @(posedge clk); #1;
         if (dif.ready_o) pulses++;
      end
      chk("flush no_pulse", 64'(pulses), 64'd0);
      chk("flush result_kept", dif.result_o, last_exp);
      run_div(32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, "after_flush");

      // Reset mid-operation: abandons op and clears result
      @(negedge clk);
      dif.start_i = 1'b1; dif.sign_i = 1'b1; dif.opa_i = 32'd99; dif.opb_i = 32'd7;
      @(posedge clk); #1;
      dif.start_i = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_mid result", dif.result_o, 64'd0);
      chk("rst_mid stall", 64'(dif.stall_o), 64'd0);
      pulses = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (dif.ready_o) pulses++;
      end
      chk("rst_mid no_pulse", 64'(pulses), 64'd0);

      // Back-to-back: start held through DONE, second op starts from IDLE
      e1 = ref_div(32'd100, 32'd9, 1'b0);
      e2 = ref_div(32'hFFFFFF00, 32'd10, 1'b1);
      @(negedge clk);
      dif.start_i = 1'b1; dif.sign_i = 1'b0; dif.opa_i = 32'd100; dif.opb_i = 32'd9;
      @(posedge clk); #1;
      n = 0;
      while (!dif.ready_o && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("b2b first latency", 64'(n), 64'd32);
      chk("b2b first result", dif.result_o, e1);
      dif.sign_i = 1'b1; dif.opa_i = 32'hFFFFFF00; dif.opb_i = 32'd10;
      @(posedge clk); #1;
      chk("b2b idle ready", 64'(dif.ready_o), 64'd0);
      chk("b2b idle stall", 64'(dif.stall_o), 64'd1);
      chk("b2b idle result_hold", dif.result_o, e1);
      @(posedge clk); #1;
      dif.start_i = 1'b0;
      n = 0;
      while (!dif.ready_o && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("b2b second latency", 64'(n), 64'd32);
      chk("b2b second result", dif.result_o, e2);
      @(posedge clk); #1;
      chk("b2b second ready_width", 64'(dif.ready_o), 64'd0);

      // Random operands against the arithmetic model
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         s = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: b = 32'($urandom_range(1, 15));
            2: b = 32'hFFFFFFFF;
            3: b = 32'h80000000;
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 5) == 0) a = 32'h80000000;
         run_div(a, b, s, ref_div(a, b, s), "rand");
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
